// File: rtl/core_pkg.sv
// Shared constants and types for the core's instruction-memory responder.
// Holds the NOP fill word, the grant FSM encoding and the response pipeline stage.
// Imported by imem_responder; imem_array is type-free and needs nothing from here.
package core_pkg;

  // Instruction word returned with an error response (addi x0, x0, 0).
  localparam logic [31:0] IMEM_NOP = 32'h0000_0013;

  // Word index carried down the pipeline: full addr[31:2], narrowed at the array.
  localparam int IMEM_IDX_W = 30;

  typedef enum logic [1:0] {
    IMEM_IDLE,
    IMEM_WAIT,
    IMEM_GRANT
  } imem_state_t;

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [IMEM_IDX_W-1:0] index;
  } imem_pipe_t;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: DEPTH_WORDS x 32, one write port, one synchronous read port.
// Latency: read data registered one edge after rd_index is presented; no backpressure.
// Ports: clock; wr_en/wr_index/wr_data write; rd_index in, rd_data out. Contents never reset.
module imem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_index,
  input  logic [31:0]       wr_data,
  input  logic [ADDR_W-1:0] rd_index,
  output logic [31:0]       rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  // Read-before-write on a same-address collision.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_index] <= wr_data;
    end
    rd_data <= mem[rd_index];
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: req/gnt/valid fetch port with optional grant wait states.
// Latency: data valid in the cycle after edge accept+LATENCY-1; up to LATENCY in flight.
// Backpressure: only via gnt (mem_en low or load_en high); responses cannot be stalled.
// Ports: clock/reset, mem_en, instr_req/addr/gnt, instr_valid/data/err, load_en/addr/data.
module imem_responder
  import core_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int GNT_WAIT    = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_en,
  input  logic        instr_req_ip,
  input  logic [31:0] instr_addr_ip,
  output logic        instr_gnt_op,
  output logic        instr_valid_op,
  output logic [31:0] instr_data_op,
  output logic        instr_err_op,
  input  logic        load_en_ip,
  input  logic [31:0] load_addr_ip,
  input  logic [31:0] load_data_ip
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);
  // wait_cnt is loaded with the WAIT cycles still to spend, including the first one.
  localparam logic [2:0]  WAIT_LOAD  = 3'((GNT_WAIT > 1) ? GNT_WAIT - 1 : 0);

  imem_state_t           state;
  logic [2:0]            wait_cnt;
  logic                  accept;
  logic                  req_err;
  logic [IMEM_IDX_W-1:0] req_index;
  imem_pipe_t            pipe [LATENCY];
  imem_pipe_t            last;
  logic [AW-1:0]         rd_index;
  logic [31:0]           rd_data;

  // ---------------- grant ----------------
  // Grant is combinational so GNT_WAIT=0 can accept in the request cycle.
  always_comb begin
    instr_gnt_op = 1'b0;
    if (!reset && mem_en && !load_en_ip) begin
      if (state == IMEM_GRANT) begin
        instr_gnt_op = 1'b1;
      end else if ((GNT_WAIT == 0) && (state == IMEM_IDLE) && instr_req_ip) begin
        instr_gnt_op = 1'b1;
      end
    end
  end

  assign accept = instr_req_ip && instr_gnt_op;

  // mem_en low or a load in progress freezes the FSM in place.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IMEM_IDLE;
      wait_cnt <= 3'd0;
    end else if (mem_en && !load_en_ip) begin
      unique case (state)
        IMEM_IDLE: begin
          if (instr_req_ip && (GNT_WAIT != 0)) begin
            if (GNT_WAIT == 1) begin
              state <= IMEM_GRANT;
            end else begin
              state    <= IMEM_WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        IMEM_WAIT: begin
          if (!instr_req_ip) begin
            state    <= IMEM_IDLE;
            wait_cnt <= 3'd0;
          end else if (wait_cnt <= 3'd1) begin
            state    <= IMEM_GRANT;
            wait_cnt <= 3'd0;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        // Unfrozen GRANT either accepts or sees req dropped: both go back to IDLE.
        IMEM_GRANT: state <= IMEM_IDLE;
        default:    state <= IMEM_IDLE;
      endcase
    end
  end

  // ---------------- decode ----------------
  assign req_index = instr_addr_ip[31:2];
  assign req_err   = (instr_addr_ip[1:0] != 2'b00) || ({1'b0, instr_addr_ip} >= ADDR_LIMIT);

  // ---------------- response pipeline ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe[i].valid <= 1'b0;
      end
    end else begin
      pipe[0] <= '{valid: accept, err: req_err, index: req_index};
      for (int i = 1; i < LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // The array read takes one edge, so it is launched from the stage before the last
  // (or straight from the request when LATENCY is 1) to land with the last stage.
  generate
    if (LATENCY == 1) begin : g_rd_direct
      assign rd_index = req_index[AW-1:0];
    end else begin : g_rd_pipe
      assign rd_index = pipe[LATENCY-2].index[AW-1:0];
    end
  endgenerate

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (AW)
  ) u_array (
    .clock   (clock),
    .wr_en   (load_en_ip),
    .wr_index(load_addr_ip[AW+1:2]),
    .wr_data (load_data_ip),
    .rd_index(rd_index),
    .rd_data (rd_data)
  );

  assign last           = pipe[LATENCY-1];
  assign instr_valid_op = last.valid;
  assign instr_err_op   = last.valid && last.err;
  // Data is forced to zero when idle so a reset also clears the stale read register's view.
  assign instr_data_op  = !last.valid ? 32'h0 : (last.err ? IMEM_NOP : rd_data);

  // Load address bits outside the word index, and the index after its last use, are don't-care.
  logic unused_bits;
  assign unused_bits = ^{load_addr_ip[31:AW+2], load_addr_ip[1:0], last.index};

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: two instances (LAT2/GW0 and LAT3/GW3).
// Expected responses are pushed on acceptance and popped by a negedge monitor.
// Grant timing is predicted from a count of eligible cycles each request has waited.
module tb_imem_responder;

  localparam int LAT0 = 2;
  localparam int GW0  = 0;
  localparam int LAT1 = 3;
  localparam int GW1  = 3;
  localparam int NWORDS = 64;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_en;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        req   [2];
  logic [31:0] addr  [2];
  logic        gnt   [2];
  logic        valid [2];
  logic [31:0] data  [2];
  logic        err   [2];

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          age [2];
  bit          rst_prev = 1'b0;
  exp_t        sbq [2][$];
  logic [31:0] model_mem [NWORDS];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  imem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT0), .GNT_WAIT(GW0)) dut0 (
    .clock(clock), .reset(reset), .mem_en(mem_en),
    .instr_req_ip(req[0]), .instr_addr_ip(addr[0]), .instr_gnt_op(gnt[0]),
    .instr_valid_op(valid[0]), .instr_data_op(data[0]), .instr_err_op(err[0]),
    .load_en_ip(load_en), .load_addr_ip(load_addr), .load_data_ip(load_data));

  imem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT1), .GNT_WAIT(GW1)) dut1 (
    .clock(clock), .reset(reset), .mem_en(mem_en),
    .instr_req_ip(req[1]), .instr_addr_ip(addr[1]), .instr_gnt_op(gnt[1]),
    .instr_valid_op(valid[1]), .instr_data_op(data[1]), .instr_err_op(err[1]),
    .load_en_ip(load_en), .load_addr_ip(load_addr), .load_data_ip(load_data));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int gw_of(input int i);
    return (i == 0) ? GW0 : GW1;
  endfunction

  // Reference decode: word-aligned and below 4*DEPTH is a hit, otherwise NOP with err.
  function automatic exp_t expect_resp(input logic [31:0] a, input int due);
    exp_t e;
    e.due  = due;
    e.err  = (a % 4 != 0) || (a >= 32'h1000);
    e.data = e.err ? 32'h0000_0013 : model_mem[a / 4];
    return e;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin : monitor
    exp_t e;
    logic exp_gnt;
    for (int i = 0; i < 2; i++) begin
      exp_gnt = !reset && mem_en && !load_en && (age[i] >= gw_of(i));
      if (req[i]) check($sformatf("gnt_dut%0d", i), 32'(gnt[i]), 32'(exp_gnt));
      if (req[i] && gnt[i]) sbq[i].push_back(expect_resp(addr[i], cyc + lat_of(i)));

      if (valid[i]) begin
        if (sbq[i].size() == 0) begin
          check($sformatf("valid_unexpected_dut%0d", i), 32'(valid[i]), 32'h0);
        end else begin
          e = sbq[i].pop_front();
          check($sformatf("resp_cycle_dut%0d", i), 32'(cyc), 32'(e.due));
          check($sformatf("resp_err_dut%0d", i), 32'(err[i]), 32'(e.err));
          check($sformatf("resp_data_dut%0d", i), data[i], e.data);
        end
      end else if (sbq[i].size() > 0 && sbq[i][0].due <= cyc) begin
        e = sbq[i].pop_front();
        check($sformatf("valid_missing_dut%0d", i), 32'(valid[i]), 32'h1);
      end

      if (rst_prev) begin
        check($sformatf("post_reset_valid_dut%0d", i), 32'(valid[i]), 32'h0);
        check($sformatf("post_reset_err_dut%0d", i), 32'(err[i]), 32'h0);
        check($sformatf("post_reset_data_dut%0d", i), data[i], 32'h0);
      end

      // Eligible waiting cycles since the request became pending.
      if (reset) begin
        age[i] = 0;
        sbq[i].delete();
      end else if (req[i] && gnt[i]) begin
        age[i] = 0;
      end else if (mem_en && !load_en) begin
        age[i] = req[i] ? age[i] + 1 : 0;
      end
    end
    rst_prev = reset;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Hold req at address a until granted; waited = non-grant cycles seen first.
  task automatic run_fetch(input int i, input logic [31:0] a, output int waited);
    bit g;
    int n;
    g = 1'b0;
    n = 0;
    req[i]  = 1'b1;
    addr[i] = a;
    while (!g && n < 200) begin
      @(negedge clock);
      g = gnt[i];
      tick();
      if (!g) n++;
    end
    if (!g) check($sformatf("grant_timeout_dut%0d", i), 32'(n), 32'h0);
    waited = n;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom % 10);
    if (r == 0) return {24'h0, 6'($urandom % NWORDS), 2'($urandom_range(1, 3))};
    if (r == 1) return ($urandom % 2 == 0) ? (32'h1000 + 32'($urandom % 64) * 4) : 32'hFFFF_FFFC;
    return 32'($urandom % NWORDS) * 4;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int w0, w1;
    bit stop;
    reset = 1'b1; mem_en = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    for (int i = 0; i < 2; i++) begin req[i] = 1'b0; addr[i] = '0; age[i] = 0; end
    repeat (3) tick();
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_gnt_dut%0d", i), 32'(gnt[i]), 32'h0);
      check($sformatf("reset_valid_dut%0d", i), 32'(valid[i]), 32'h0);
      check($sformatf("reset_data_dut%0d", i), data[i], 32'h0);
    end
    tick();
    reset = 1'b0;

    // Preload: words 0..3 = A0..A3, the rest random.
    load_en = 1'b1;
    for (int k = 0; k < NWORDS; k++) begin
      load_addr = 32'(k) * 4;
      load_data = (k < 4) ? 32'hA0 + 32'(k) : $urandom;
      model_mem[k] = load_data;
      tick();
    end
    load_en = 1'b0;
    tick();

    // Back-to-back on dut0; wait-state grant on dut1.
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          run_fetch(0, 32'(k) * 4, w0);
          check($sformatf("b2b_wait_%0d", k), 32'(w0), 32'h0);
        end
        req[0] = 1'b0;
      end
      begin
        run_fetch(1, 32'h8, w1);
        check("gntwait_dut1", 32'(w1), 32'(GW1));
        req[1] = 1'b0;
      end
    join
    repeat (6) tick();

    // Misaligned and out-of-range requests.
    fork
      begin run_fetch(0, 32'h6, w0); run_fetch(0, 32'h1000, w0); req[0] = 1'b0; end
      begin run_fetch(1, 32'h6, w1); run_fetch(1, 32'h1000, w1); req[1] = 1'b0; end
    join
    repeat (6) tick();

    // mem_en low with a response in flight on dut1: it drains, no grants.
    run_fetch(1, 32'h10, w1);
    mem_en  = 1'b0;
    req[0]  = 1'b1; addr[0] = 32'h14;
    req[1]  = 1'b1; addr[1] = 32'h18;
    repeat (6) begin
      @(negedge clock);
      check("mem_en_block_dut0", 32'(gnt[0]), 32'h0);
      check("mem_en_block_dut1", 32'(gnt[1]), 32'h0);
      tick();
    end
    mem_en = 1'b1;
    fork
      run_fetch(0, 32'h14, w0);
      run_fetch(1, 32'h18, w1);
    join
    check("mem_en_resume_dut0", 32'(w0), 32'h0);
    check("mem_en_resume_dut1", 32'(w1), 32'(GW1));
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (6) tick();

    // Load collides with a request in GRANT (dut1) and in IDLE (dut0).
    req[1] = 1'b1; addr[1] = 32'h20;
    repeat (GW1) tick();
    req[0] = 1'b1; addr[0] = 32'h20;
    load_en = 1'b1; load_addr = 32'h20; load_data = 32'hDEAD_BEEF;
    model_mem[8] = 32'hDEAD_BEEF;
    @(negedge clock);
    check("load_blocks_gnt_dut0", 32'(gnt[0]), 32'h0);
    check("load_blocks_gnt_dut1", 32'(gnt[1]), 32'h0);
    tick();
    load_en = 1'b0;
    fork
      run_fetch(0, 32'h20, w0);
      run_fetch(1, 32'h20, w1);
    join
    check("after_load_wait_dut0", 32'(w0), 32'h0);
    check("after_load_wait_dut1", 32'(w1), 32'h0);
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (6) tick();

    // Reset mid-flight, then show contents survived.
    run_fetch(0, 32'h0, w0);
    run_fetch(0, 32'h4, w0);
    req[0] = 1'b0;
    reset  = 1'b1;
    tick();
    reset  = 1'b0;
    repeat (4) tick();
    run_fetch(0, 32'h0, w0);
    req[0] = 1'b0;
    repeat (6) tick();

    // Randomized traffic on both instances with mem_en toggling.
    stop = 1'b0;
    fork
      begin
        fork
          begin
            int w;
            for (int n = 0; n < 120; n++) begin
              run_fetch(0, rand_addr(), w);
              if ($urandom % 3 == 0) begin req[0] = 1'b0; repeat ($urandom % 3) tick(); end
            end
            req[0] = 1'b0;
          end
          begin
            int w;
            for (int n = 0; n < 120; n++) begin
              run_fetch(1, rand_addr(), w);
              if ($urandom % 3 == 0) begin req[1] = 1'b0; repeat ($urandom % 3) tick(); end
            end
            req[1] = 1'b0;
          end
        join
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          if ($urandom % 6 == 0) mem_en = ~mem_en;
          tick();
        end
        mem_en = 1'b1;
      end
    join
    repeat (10) tick();
    check("drain_dut0", 32'(sbq[0].size()), 32'h0);
    check("drain_dut1", 32'(sbq[1].size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the 5-stage RISC-V core. It is the memory side of the fetch request/grant/valid handshake. It accepts word fetch requests from the fetch unit and optionally inserts programmable wait states before granting. It returns the instruction word a fixed number of cycles after acceptance, with up to LATENCY requests in flight. A testbench load port preloads program contents.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words stored; power of two.
- LATENCY, 2: edges from acceptance to data valid; legal range 1..4.
- GNT_WAIT, 0: cycles a new request is held before grant is raised; range 0..7.

Ports:
- clock  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- mem_en  in  1  global enable; low blocks new grants only.
- instr_req_ip  in  1  fetch request from fetch unit.
- instr_addr_ip  in  32  byte address; stable while req high and not granted.
- instr_gnt_op  out  1  grant; request accepted at an edge where req and gnt are both 1.
- instr_valid_op  out  1  response valid, one cycle per accepted request.
- instr_data_op  out  32  instruction word.
- instr_err_op  out  1  response error flag; meaningful only with valid.
- load_en_ip  in  1  preload write strobe.
- load_addr_ip  in  32  preload byte address; bits [1:0] ignored.
- load_data_ip  in  32  preload word.

## Operation
- Grant FSM has three states: IDLE, WAIT, GRANT.
  - IDLE: if req && mem_en && !load_en, go to WAIT with wait_cnt=GNT_WAIT-1. When GNT_WAIT=0, gnt is instead asserted combinationally in IDLE.
  - WAIT: decrement wait_cnt each cycle; at 0, go to GRANT. If req drops, return to IDLE.
  - GRANT: gnt=1 while mem_en && !load_en. On acceptance, return to IDLE. If req drops, return to IDLE.
- Throughput:
  - GNT_WAIT=0 allows back-to-back acceptance, one per cycle.
  - GNT_WAIT=N gives N idle cycles before each grant.
- Address decode:
  - Word index = addr[log2(DEPTH_WORDS)+1:2].
  - Error if addr[1:0]!=0 or addr ≥ 4*DEPTH_WORDS.
  - An error response carries data 32'h0000_0013 (NOP) with err=1.
- Response pipeline:
  - Shift register of LATENCY stages, each holding {valid, err, index}.
  - The array read is synchronous and aligned so that data, valid and err leave the last stage together.
- Load port: a write occurs at the edge when load_en=1. Load has priority: gnt is forced to 0 that cycle and the FSM holds its state.
- mem_en=0 blocks grants and freezes the FSM in its current state. In-flight responses still drain.
- reset:
  - FSM goes to IDLE; wait_cnt=0.
  - Pipeline valids are cleared, so in-flight responses are dropped.
  - gnt, valid, err are 0 and data is 32'h0.
  - Array contents are preserved.

## Timing
- Acceptance at edge E0 produces valid=1 in the cycle after edge E0+LATENCY-1. With LATENCY=1, the response appears in the cycle right after E0.
- valid pulses for exactly one cycle per accepted request. No backpressure exists, so the fetch unit must sink every response.
- Responses are delivered in acceptance order. At most LATENCY requests are outstanding.
- A load to address A at edge E followed by acceptance of A at a later edge returns the new data.
- Reset asserted mid-flight: the output is 0 from the cycle after the reset edge. The first grant after reset deasserts is no earlier than the first cycle with reset=0.

## Structure
- Constants and types go in CORE_PKG:
  - IMEM_NOP = 32'h0000_0013.
  - typedef enum {IMEM_IDLE, IMEM_WAIT, IMEM_GRANT} imem_state_t.
  - packed struct imem_pipe_t {valid, err, index}.
- One sub-module, imem_array: single write port and one synchronous read port, DEPTH_WORDS×32.
- Top level holds the FSM, decode and response pipeline.

## Test plan
- Preload words 0..3 with 0xA0..0xA3. GNT_WAIT=0, LATENCY=2, req held at addresses 0,4,8,12 on consecutive cycles → four grants back-to-back; valid on cycles 2–5 with data 0xA0..0xA3 in order.
- GNT_WAIT=3, req to 0x8 → gnt rises exactly 3 cycles after req; data 0xA2 valid LATENCY edges after acceptance.
- Request to 0x6 and to 4*DEPTH_WORDS → each returns valid=1, err=1, data 0x00000013.
- Request in flight with LATENCY=3, then mem_en=0 → response still delivered; no further grants until mem_en=1.
- load_en=1 in the same cycle as req in GRANT state → gnt=0 that cycle; grant follows next cycle and returns the newly loaded value when the address matches.
- Two requests in flight, reset pulsed for 1 cycle → no valid thereafter, all outputs 0; a later fetch of 0x0 returns 0xA0, showing contents are preserved.
